// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: word width, architectural register
// indices and the RegDst write-address select encodings.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;
  localparam int NREGS  = 32;

  localparam logic [IDX_W-1:0] REG_ZERO = 5'd0;
  localparam logic [IDX_W-1:0] REG_SP   = 5'd29;
  localparam logic [IDX_W-1:0] REG_RA   = 5'd31;

  // Upstream RegDst mux select: which field/constant becomes write_reg.
  typedef enum logic [2:0] {
    REGDST_RT = 3'b000,
    REGDST_SP = 3'b001,
    REGDST_RA = 3'b010,
    REGDST_RD = 3'b011,
    REGDST_RS = 3'b100
  } regdst_e;

endpackage

// File: rtl/reg_read_port.sv
// One registered read port of the register bank. Captures on read_en,
// forwards a same-edge write to the same index, and pins index 0 to zero.
module reg_read_port
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              read_en,
  input  logic [IDX_W-1:0]  read_reg,
  input  logic [WORD_W-1:0] arr_data,
  input  logic              reg_write,
  input  logic [IDX_W-1:0]  write_reg,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data
);

  logic fwd_hit;

  // Write-first: a concurrent write to the read index wins over the array.
  assign fwd_hit = reg_write && (write_reg == read_reg);

  // Output latch: reset clears, read_en captures, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset)
      read_data <= '0;
    else if (read_en) begin
      if (read_reg == REG_ZERO) read_data <= '0;
      else if (fwd_hit)         read_data <= write_data;
      else                      read_data <= arr_data;
    end
  end

endmodule

// File: rtl/reg_bank_rw.sv
// 32 x 32 MIPS general-purpose register bank: one write port, two
// registered read ports (A/B operands) and a combinational debug view.
module reg_bank_rw
  import mips_pkg::*;
#(
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter logic [31:0] RA_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  input  logic        read_en,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data
);

  localparam int NPORTS = 2;

  logic [NREGS-1:0][WORD_W-1:0]  regs;
  logic [NPORTS-1:0][IDX_W-1:0]  rsel;
  logic [NPORTS-1:0][WORD_W-1:0] rarr;
  logic [NPORTS-1:0][WORD_W-1:0] rdat;

  // Storage: reset image with $sp/$ra preset; index 0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      regs[REG_SP] <= SP_RESET;
      regs[REG_RA] <= RA_RESET;
    end else if (reg_write && (write_reg != REG_ZERO)) begin
      regs[write_reg] <= write_data;
    end
  end

  assign rsel[0]    = read_reg1;
  assign rsel[1]    = read_reg2;
  assign read_data1 = rdat[0];
  assign read_data2 = rdat[1];

  // Read ports share the write bus for forwarding.
  for (genvar p = 0; p < NPORTS; p++) begin : g_rp
    assign rarr[p] = regs[rsel[p]];
    reg_read_port u_rp (
      .clk        (clk),
      .reset      (reset),
      .read_en    (read_en),
      .read_reg   (rsel[p]),
      .arr_data   (rarr[p]),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_data  (rdat[p])
    );
  end

  // Raw array view, no forwarding; slot 0 holds zero by construction.
  assign dbg_data = (dbg_sel == REG_ZERO) ? '0 : regs[dbg_sel];

endmodule

// File: tb/tb_reg_bank_rw.sv
// Directed checks for reg_bank_rw: reset image, write/read latency,
// zero register, forwarding, hold, reset priority and RegDst targets.
module tb_reg_bank_rw;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic        read_en;
  logic [31:0] read_data1, read_data2;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;

  int nvec = 0;
  int nerr = 0;

  reg_bank_rw #(.SP_RESET(32'd227), .RA_RESET(32'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_en    (read_en),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    dbg_sel = idx;
    #1;
    chk($sformatf("%s r%0d", tag, idx), dbg_data, exp);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    reg_write = 1'b1; write_reg = idx; write_data = d;
    step();
    reg_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0; read_en = 1'b0; dbg_sel = '0;
    step();
    reset = 1'b0;

    // Reset image
    chk("rst rd1", read_data1, 32'd0);
    chk("rst rd2", read_data2, 32'd0);
    for (int i = 0; i < 32; i++)
      dbg(i[4:0], (i == 29) ? 32'd227 : 32'd0, "rst");

    // Write then read one edge later
    wr(5'd8, 32'hDEADBEEF);
    dbg(5'd8, 32'hDEADBEEF, "wr");
    read_reg1 = 5'd8; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("rd r8", read_data1, 32'hDEADBEEF);

    // Zero register: write ignored, reads of 0 give 0 even with same-edge write
    read_reg1 = 5'd0; read_reg2 = 5'd0; read_en = 1'b1;
    wr(5'd0, 32'hFFFFFFFF);
    read_en = 1'b0;
    chk("zero rd1", read_data1, 32'd0);
    chk("zero rd2", read_data2, 32'd0);
    dbg(5'd0, 32'd0, "zero");

    // Forwarding on both ports
    wr(5'd5, 32'h11);
    read_reg1 = 5'd5; read_reg2 = 5'd5; read_en = 1'b1;
    wr(5'd5, 32'h22);
    read_en = 1'b0;
    chk("fwd rd1", read_data1, 32'h22);
    chk("fwd rd2", read_data2, 32'h22);
    dbg(5'd5, 32'h22, "fwd");

    // Forwarding on one port only; the other reads the array
    read_reg1 = 5'd5; read_reg2 = 5'd8; read_en = 1'b1;
    wr(5'd8, 32'h33);
    read_en = 1'b0;
    chk("fwd1 rd1", read_data1, 32'h22);
    chk("fwd1 rd2", read_data2, 32'h33);

    // Hold while read_en is low
    read_reg1 = 5'd29; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("cap sp", read_data1, 32'd227);
    wr(5'd29, 32'h100);
    chk("hold rd1", read_data1, 32'd227);
    dbg(5'd29, 32'h100, "hold");

    // Reset beats a concurrent write and read capture
    reset = 1'b1; read_en = 1'b1; read_reg2 = 5'd8;
    wr(5'd29, 32'h55);
    reset = 1'b0; read_en = 1'b0;
    chk("rstp rd1", read_data1, 32'd0);
    chk("rstp rd2", read_data2, 32'd0);
    dbg(5'd29, 32'd227, "rstp");
    dbg(5'd8, 32'd0, "rstp");
    dbg(5'd5, 32'd0, "rstp");

    // RegDst constant targets; everything else untouched
    wr(5'd31, 32'h31);
    wr(5'd29, 32'h1D);
    for (int i = 0; i < 32; i++)
      dbg(i[4:0], (i == 31) ? 32'h31 : (i == 29) ? 32'h1D : 32'd0, "rdst");
    read_reg1 = 5'd29; read_reg2 = 5'd31; read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("rdst rd1", read_data1, 32'h1D);
    chk("rdst rd2", read_data2, 32'h31);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
